// File: rtl/haru_axis_pkg.sv
// Shared types, defaults and helpers for the HARU AXI4-Stream blocks.
package haru_axis_pkg;

  localparam int unsigned DefTdataWidth  = 32;
  localparam int unsigned DefFifoDepth   = 16;
  localparam int unsigned DefStartCount  = 32;
  localparam int unsigned DefPktLenWidth = 16;

  typedef enum logic [0:0] {WAIT_START, STREAM} axis_state_e;

  // Ceiling log2, never below 1 so it can size a vector directly.
  function automatic int unsigned clogb2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/dtw_sync_fifo.sv
// Single-clock FIFO with registered occupancy; read data is valid alongside rd_en.
module dtw_sync_fifo
  import haru_axis_pkg::*;
#(
  parameter int unsigned Width = 33,
  parameter int unsigned Depth = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             wr_en,
  input  logic [Width-1:0]                 din,
  input  logic                             rd_en,
  output logic [Width-1:0]                 dout,
  output logic                             full,
  output logic                             empty,
  output logic [clogb2(Depth+1)-1:0]       level
);

  localparam int unsigned PtrW = clogb2(Depth);
  localparam int unsigned LvlW = clogb2(Depth + 1);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]  count_q;
  logic             wr_ok, rd_ok;

  assign full  = (count_q == LvlW'(Depth));
  assign empty = (count_q == '0);
  assign level = count_q;
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;
  assign dout  = mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_q] <= din;
  end

  // Depth is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (rd_ok) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (wr_ok && !rd_ok)      count_q <= count_q + LvlW'(1);
      else if (!wr_ok && rd_ok) count_q <= count_q - LvlW'(1);
    end
  end

endmodule

// File: rtl/dtw_axis_result_tx.sv
// AXI4-Stream master draining DTW results from a FIFO, with beat-count or
// producer-marked packet framing, a start-up delay and a sticky overflow flag.
module dtw_axis_result_tx
  import haru_axis_pkg::*;
#(
  parameter int unsigned C_M_AXIS_TDATA_WIDTH = DefTdataWidth,
  parameter int unsigned C_FIFO_DEPTH         = DefFifoDepth,
  parameter int unsigned C_M_START_COUNT      = DefStartCount,
  parameter int unsigned C_PKT_LEN_WIDTH      = DefPktLenWidth
) (
  input  logic                                M_AXIS_ACLK,
  input  logic                                M_AXIS_ARESETN,
  input  logic                                stream_en,
  input  logic [C_PKT_LEN_WIDTH-1:0]          pkt_len,
  input  logic                                dtw_fifo_wren,
  input  logic [C_M_AXIS_TDATA_WIDTH-1:0]     dtw_fifo_din,
  input  logic                                dtw_fifo_last,
  output logic                                dtw_fifo_full,
  output logic [clogb2(C_FIFO_DEPTH+1)-1:0]   dtw_fifo_level,
  output logic                                ovf,
  input  logic                                ovf_clr,
  output logic                                M_AXIS_TVALID,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]     M_AXIS_TDATA,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]   M_AXIS_TSTRB,
  output logic                                M_AXIS_TLAST,
  input  logic                                M_AXIS_TREADY
);

  localparam int unsigned W    = C_M_AXIS_TDATA_WIDTH;
  localparam int unsigned PW   = C_PKT_LEN_WIDTH;
  localparam int unsigned CntW = clogb2(C_M_START_COUNT + 1);
  localparam logic [CntW-1:0] StartLast = CntW'(C_M_START_COUNT - 1);

  axis_state_e     state_q;
  logic [CntW-1:0] start_cnt_q;
  logic [PW-1:0]   beat_q;
  logic            tvalid_q, tlast_q, ovf_q;
  logic [W-1:0]    tdata_q;

  logic [W:0]      fifo_dout;
  logic            fifo_empty, fifo_full;
  logic            handshake, load, auto_last;
  logic [PW:0]     beat_eff, pkt_last_idx;

  dtw_sync_fifo #(
    .Width (W + 1),
    .Depth (C_FIFO_DEPTH)
  ) u_fifo (
    .clk   (M_AXIS_ACLK),
    .rst_n (M_AXIS_ARESETN),
    .wr_en (dtw_fifo_wren),
    .din   ({dtw_fifo_last, dtw_fifo_din}),
    .rd_en (load),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (dtw_fifo_level)
  );

  assign handshake = tvalid_q && M_AXIS_TREADY;
  assign load      = (state_q == STREAM) && stream_en && !fifo_empty
                     && (!tvalid_q || M_AXIS_TREADY);

  // Position of the word being loaded: the beat leaving this cycle already counts.
  assign beat_eff     = (handshake && tlast_q) ? '0
                        : {1'b0, beat_q} + {{PW{1'b0}}, handshake};
  assign pkt_last_idx = {1'b0, pkt_len} - {{PW{1'b0}}, 1'b1};
  assign auto_last    = (pkt_len != '0) && (beat_eff == pkt_last_idx);

  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      state_q     <= WAIT_START;
      start_cnt_q <= '0;
    end else begin
      unique case (state_q)
        WAIT_START: begin
          if (start_cnt_q == StartLast) state_q <= STREAM;
          else                          start_cnt_q <= start_cnt_q + CntW'(1);
        end
        STREAM:     state_q <= STREAM;
        default:    state_q <= WAIT_START;
      endcase
    end
  end

  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= '0;
      beat_q   <= '0;
    end else begin
      if (load) begin
        tvalid_q <= 1'b1;
        tdata_q  <= fifo_dout[W-1:0];
        tlast_q  <= fifo_dout[W] | auto_last;
      end else if (handshake) begin
        tvalid_q <= 1'b0;
      end
      if (handshake) begin
        if (tlast_q)          beat_q <= '0;
        else if (beat_q != '1) beat_q <= beat_q + PW'(1);
      end
    end
  end

  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN)              ovf_q <= 1'b0;
    else if (dtw_fifo_wren && fifo_full) ovf_q <= 1'b1;
    else if (ovf_clr)                 ovf_q <= 1'b0;
  end

  assign dtw_fifo_full = fifo_full;
  assign ovf           = ovf_q;
  assign M_AXIS_TVALID = tvalid_q;
  assign M_AXIS_TDATA  = tdata_q;
  assign M_AXIS_TLAST  = tlast_q;
  assign M_AXIS_TSTRB  = '1;

endmodule

// File: doc/dtw_axis_result_tx.md
# dtw_axis_result_tx

Parametrised AXI4-Stream master that buffers DTW result words from the HARU compute core in a configurable-depth FIFO and streams them to the DMA. Packets are framed either by a programmable beat count or by an explicit end-of-packet marker from the producer. It sits between the DTW engine's result port and the S2MM channel of the AXI DMA. The block adds a sticky overflow flag and a streaming-enable gate.

## Interface
Parameters:
- C_M_AXIS_TDATA_WIDTH, 32: TDATA and FIFO word width; multiple of 8.
- C_FIFO_DEPTH, 16: FIFO entries; power of two, ≥ 2.
- C_M_START_COUNT, 32: cycles after reset release before the first TVALID.
- C_PKT_LEN_WIDTH, 16: width of the `pkt_len` input.

Ports:
- M_AXIS_ACLK  in  1  single clock for the whole block.
- M_AXIS_ARESETN  in  1  reset; asynchronous assert, active-low.
- stream_en  in  1  when 0, no new word is loaded into the output stage.
- pkt_len  in  C_PKT_LEN_WIDTH  beats per packet; 0 means no auto-TLAST.
- dtw_fifo_wren  in  1  write strobe from the DTW core.
- dtw_fifo_din  in  C_M_AXIS_TDATA_WIDTH  result word.
- dtw_fifo_last  in  1  marks the written word as end-of-packet.
- dtw_fifo_full  out  1  FIFO holds C_FIFO_DEPTH entries.
- dtw_fifo_level  out  clog2(C_FIFO_DEPTH+1)  FIFO entries; excludes the output stage.
- ovf  out  1  sticky: a write was attempted while full.
- ovf_clr  in  1  clears `ovf`.
- M_AXIS_TVALID  out  1  
- M_AXIS_TDATA  out  C_M_AXIS_TDATA_WIDTH  
- M_AXIS_TSTRB  out  C_M_AXIS_TDATA_WIDTH/8  constant all-ones.
- M_AXIS_TLAST  out  1  
- M_AXIS_TREADY  in  1  

## Operation
- State machine has two states:
  - WAIT_START: the reset state. The start counter increments each cycle. When it reaches C_M_START_COUNT-1, the FSM moves to STREAM.
  - STREAM: held until reset; there is no return to idle.
- FIFO:
  - Each entry is {last, data}.
  - A write is accepted when `dtw_fifo_wren && !full`.
  - A write while full is dropped and sets `ovf`.
  - Pointers wrap modulo C_FIFO_DEPTH.
  - Simultaneous accepted write and read leaves the level unchanged. A write when full is never accepted, even if a read occurs in the same cycle.
- Output stage (a register holding one word):
  - A load occurs when all of the following hold: state is STREAM, `stream_en` is 1, the level is above 0, and either TVALID is 0 or TREADY is 1.
  - A load pops the FIFO and sets TVALID.
  - TVALID clears when a handshake happens and there is no load in the same cycle.
  - Once TVALID is 1, TDATA and TLAST are held stable until the handshake, regardless of `stream_en`.
- Framing:
  - The beat counter increments on each handshake and clears on a handshake carrying TLAST.
  - TLAST for the loaded word = stored last bit OR (`pkt_len` ≠ 0 AND beat count at load time == `pkt_len`-1). Beat count at load time counts the word being loaded.
  - `pkt_len` is sampled at each load. Changing it mid-packet takes effect at the next load.
  - The beat counter saturates; it never wraps.
- `ovf`: if `ovf_clr` and an overflowing write occur in the same cycle, the set wins.

## Timing
- Reset values: TVALID 0, TLAST 0, TDATA 0, `ovf` 0, `full` 0, `level` 0. The state returns to WAIT_START and the start counter, beat counter and pointers clear. All of this happens immediately on assertion (asynchronous). Buffered data is lost.
- Latency: a word written in cycle n with the FIFO otherwise empty appears on TDATA in cycle n+2 at the earliest.
- Throughput: one beat per cycle with TREADY held high and the FIFO non-empty.
- `full` and `level` are registered-count derived. They reflect accepted writes and reads one cycle after the edge.
- Writes are accepted during WAIT_START. TVALID stays 0 until the cycle after the FSM enters STREAM.

## Structure
- Shared package `haru_axis_pkg`:
  - `clogb2` function.
  - FSM state type {WAIT_START, STREAM}.
  - Default width constants.
- Sub-module `dtw_sync_fifo`:
  - Parameters: width, depth.
  - Contents: storage, pointers, level and full/empty.
  - Write side: wr_en/din. Read side: rd_en/dout (data valid in the same cycle as rd_en).
- The top level holds the FSM, output stage, framing and overflow logic.

## Test plan
- Startup gate:
  - Stimulus: reset release, 3 words written in cycles 1–3, TREADY=1.
  - Required response: TVALID first rises only after C_M_START_COUNT cycles. Words appear in order on consecutive cycles. TLAST=0 (`pkt_len`=0).
- Auto framing:
  - Stimulus: `pkt_len`=4, 10 words 0..9 streamed, TREADY=1.
  - Required response: TLAST on words 3 and 7. Words 8 and 9 have TLAST=0.
- Explicit last:
  - Stimulus: `pkt_len`=8, words 0..2 with `dtw_fifo_last` on word 2, then 8 more words.
  - Required response: TLAST on word 2. The beat count restarts, so the next TLAST falls 8 beats later.
- Backpressure:
  - Stimulus: TREADY toggling pseudo-randomly, 64 words.
  - Required response: no loss or duplication. TDATA and TLAST are stable while TVALID=1 and TREADY=0.
- Full/overflow (C_FIFO_DEPTH=16):
  - Stimulus: TREADY=0 and 18 writes.
  - Required response: the output stage holds 1 word and `level`=16 with `full`=1. One further write is dropped and `ovf`=1. `ovf_clr` clears it.
- Async reset mid-packet:
  - Stimulus: assert reset while TVALID=1.
  - Required response: TVALID drops to 0 immediately and `level`=0. The start delay is re-applied after release.
